// File: rtl/inner_wb_mem_responder_pkg.sv
// rtl/inner_wb_mem_responder_pkg.sv - shared state encoding and burst-length constants
package inner_wb_mem_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR_ACK,
      ST_WR_WAIT,
      ST_ERR
   } state_t;

   localparam int BURST_LEN_4 = 4;
   localparam int BURST_LEN_8 = 8;

   // Returns the number of beats remaining after the first one.
   function automatic logic [2:0] burst_beats_after_first(input logic burst_4, input logic burst_8);
      if (burst_8)
         return 3'(BURST_LEN_8 - 1);
      else if (burst_4)
         return 3'(BURST_LEN_4 - 1);
      else
         return 3'd0;
   endfunction

endpackage

// File: rtl/inner_wb_mem_responder_burst_addr_gen.sv
// rtl/inner_wb_mem_responder_burst_addr_gen.sv - linear burst address and beat counter
module wb_burst_addr_gen #(
   parameter int MEM_AW = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              load,
   input  logic              step,
   input  logic [MEM_AW-1:0] load_adr,
   input  logic [2:0]        load_beats,
   output logic [MEM_AW-1:0] next_adr,
   output logic              last_beat,
   output logic              window_overflow
);

   logic [MEM_AW-1:0] adr_q;
   logic [2:0]        beats_left;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         adr_q      <= '0;
         beats_left <= '0;
      end else if (load) begin
         adr_q      <= load_adr;
         beats_left <= load_beats;
      end else if (step) begin
         adr_q      <= next_adr;
         beats_left <= beats_left - 3'd1;
      end
   end

   assign next_adr        = adr_q + MEM_AW'(1);
   assign last_beat       = (beats_left == 3'd0);
   // Another beat is wanted but the window has no word left for it.
   assign window_overflow = (&adr_q) && !last_beat;

endmodule

// File: rtl/inner_wb_mem_responder.sv
// rtl/inner_wb_mem_responder.sv - inner-bus Wishbone responder backing an on-chip SRAM window
module inner_wb_mem_responder
   import inner_wb_mem_responder_pkg::*;
#(
   parameter int                   WB_ADDR_W = 24,
   parameter int                   DATA_W    = 16,
   parameter int                   MEM_AW    = 10,
   parameter logic [WB_ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   input  logic [WB_ADDR_W-1:0]  wb_adr,
   input  logic [DATA_W/8-1:0]   wb_sel,
   input  logic [DATA_W-1:0]     wb_i_dat,
   output logic [DATA_W-1:0]     wb_o_dat,
   input  logic                  wb_4_burst,
   input  logic                  wb_8_burst,
   output logic                  wb_ack,
   output logic                  wb_err,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [MEM_AW-1:0]     mem_adr,
   output logic [DATA_W/8-1:0]   mem_wmask,
   output logic [DATA_W-1:0]     mem_wdat,
   input  logic [DATA_W-1:0]     mem_rdat
);

   state_t                state;
   logic [WB_ADDR_W-1:0]  offset;
   logic                  req;
   logic                  bad_req;
   logic                  load;
   logic                  step;
   logic [MEM_AW-1:0]     next_adr;
   logic                  last_beat;
   logic                  window_overflow;

   assign wb_o_dat = mem_rdat;
   assign req      = wb_cyc & wb_stb;
   assign offset   = wb_adr - BASE_ADDR;
   assign bad_req  = (wb_4_burst & wb_8_burst) | (offset[WB_ADDR_W-1:MEM_AW] != '0);

   wb_burst_addr_gen #(.MEM_AW(MEM_AW)) u_addr_gen (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .load            (load),
      .step            (step),
      .load_adr        (offset[MEM_AW-1:0]),
      .load_beats      (burst_beats_after_first(wb_4_burst, wb_8_burst)),
      .next_adr        (next_adr),
      .last_beat       (last_beat),
      .window_overflow (window_overflow)
   );

   // The SRAM port is driven combinationally so the first access leaves in the accept cycle;
   // everything is held quiet while reset is asserted.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_adr   = '0;
      mem_wmask = '0;
      mem_wdat  = '0;
      load      = 1'b0;
      step      = 1'b0;
      if (i_rst) begin
         case (state)
            ST_IDLE: if (req && !bad_req) begin
               mem_en  = 1'b1;
               mem_we  = wb_we;
               mem_adr = offset[MEM_AW-1:0];
               load    = 1'b1;
               if (wb_we) begin
                  mem_wmask = wb_sel;
                  mem_wdat  = wb_i_dat;
               end
            end
            ST_RD: if (wb_cyc && !last_beat && !window_overflow) begin
               mem_en  = 1'b1;
               mem_adr = next_adr;
               step    = 1'b1;
            end
            ST_WR_WAIT: if (req && !window_overflow) begin
               mem_en    = 1'b1;
               mem_we    = 1'b1;
               mem_adr   = next_adr;
               mem_wmask = wb_sel;
               mem_wdat  = wb_i_dat;
               step      = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state  <= ST_IDLE;
         wb_ack <= 1'b0;
         wb_err <= 1'b0;
      end else begin
         wb_ack <= 1'b0;
         wb_err <= 1'b0;
         case (state)
            ST_IDLE: if (req) begin
               if (bad_req) begin
                  state  <= ST_ERR;
                  wb_err <= 1'b1;
               end else begin
                  state  <= wb_we ? ST_WR_ACK : ST_RD;
                  wb_ack <= 1'b1;
               end
            end
            ST_RD: begin
               if (!wb_cyc || last_beat) begin
                  state <= ST_IDLE;
               end else if (window_overflow) begin
                  state  <= ST_ERR;
                  wb_err <= 1'b1;
               end else begin
                  wb_ack <= 1'b1;
               end
            end
            ST_WR_ACK: state <= (!wb_cyc || last_beat) ? ST_IDLE : ST_WR_WAIT;
            ST_WR_WAIT: begin
               if (!wb_cyc) begin
                  state <= ST_IDLE;
               end else if (wb_stb) begin
                  if (window_overflow) begin
                     state  <= ST_ERR;
                     wb_err <= 1'b1;
                  end else begin
                     state  <= ST_WR_ACK;
                     wb_ack <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
